// File: rtl/seq_fetch_queue.sv
// Circular instruction/PC queue between instruction memory and decode.
// Each side uses a valid/ready handshake. Flush and halt act on the whole queue.
module seq_fetch_queue #(
  parameter int ADDRESS_SIZE = 10,
  parameter int INSTR_WIDTH  = 16,
  parameter int DEPTH        = 4,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_sys_halt,
  input  logic                    i_in_valid,
  input  logic [INSTR_WIDTH-1:0]  i_instruction,
  input  logic [ADDRESS_SIZE-1:0] i_pc,
  output logic                    o_in_ready,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [INSTR_WIDTH-1:0]  o_instruction,
  output logic [ADDRESS_SIZE-1:0] o_pc,
  output logic [CNT_W-1:0]        o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [INSTR_WIDTH-1:0]  instrMem_q [DEPTH];
  logic [ADDRESS_SIZE-1:0] pcMem_q    [DEPTH];
  logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    push, pop, notEmpty;

  assign notEmpty    = (count_q != '0);
  assign o_in_ready  = !i_sys_halt && !i_flush && (count_q < FULL_COUNT);
  assign o_out_valid = !i_sys_halt && notEmpty;
  assign push        = i_in_valid && o_in_ready;
  assign pop         = o_out_valid && i_out_ready && !i_flush;

  // Head is presented even while halted, so decode sees a stable value; empty reads as NOP.
  assign o_instruction = notEmpty ? instrMem_q[rdPtr_q] : '0;
  assign o_pc          = notEmpty ? pcMem_q[rdPtr_q]    : '0;
  assign o_count       = count_q;

  // Halt needs no explicit branch: it forces push and pop low, so everything holds.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (i_flush && !i_sys_halt) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      instrMem_q[wrPtr_q] <= i_instruction;
      pcMem_q[wrPtr_q]    <= i_pc;
    end
  end

endmodule

// File: tb/tb_seq_fetch_queue.sv
// Scoreboard bench for seq_fetch_queue: directed scenarios followed by random traffic.
// An SV-queue reference model predicts the status outputs and the order of popped entries.
module tb_seq_fetch_queue;

  localparam int ADDRESS_SIZE = 10;
  localparam int INSTR_WIDTH  = 16;
  localparam int DEPTH        = 4;
  localparam int CNT_W        = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]  instr;
    logic [ADDRESS_SIZE-1:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rstIn = 1'b1;
  logic flushIn = 1'b0;
  logic haltIn = 1'b0;
  logic inValid = 1'b0;
  logic [INSTR_WIDTH-1:0]  instrIn = '0;
  logic [ADDRESS_SIZE-1:0] pcIn = '0;
  logic outReady = 1'b0;
  logic oInReady, oOutValid;
  logic [INSTR_WIDTH-1:0]  oInstr;
  logic [ADDRESS_SIZE-1:0] oPc;
  logic [CNT_W-1:0]        oCount;

  entry_t refQ[$];
  entry_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_fetch_queue #(
    .ADDRESS_SIZE(ADDRESS_SIZE), .INSTR_WIDTH(INSTR_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rstIn), .i_flush(flushIn), .i_sys_halt(haltIn),
    .i_in_valid(inValid), .i_instruction(instrIn), .i_pc(pcIn),
    .o_in_ready(oInReady), .o_out_valid(oOutValid), .i_out_ready(outReady),
    .o_instruction(oInstr), .o_pc(oPc), .o_count(oCount)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // One cycle: drive inputs after the edge, check status, advance the reference model.
  task automatic applyStimulus(input logic valid, input logic [INSTR_WIDTH-1:0] instr,
                               input logic [ADDRESS_SIZE-1:0] pc, input logic outRdy,
                               input logic flush, input logic halt, input logic rst);
    logic expReady, expValid, doPush, doPop;
    entry_t e;
    inValid = valid; instrIn = instr; pcIn = pc;
    outReady = outRdy; flushIn = flush; haltIn = halt; rstIn = rst;
    #1;
    expReady = !halt && !flush && (refQ.size() < DEPTH);
    expValid = !halt && (refQ.size() != 0);
    checkOutput("count", 32'(oCount), 32'(refQ.size()));
    checkOutput("in_ready", 32'(oInReady), 32'(expReady));
    checkOutput("out_valid", 32'(oOutValid), 32'(expValid));
    if (refQ.size() == 0) begin
      checkOutput("empty_instr", 32'(oInstr), 32'd0);
      checkOutput("empty_pc", 32'(oPc), 32'd0);
    end else begin
      checkOutput("head_instr", 32'(oInstr), 32'(refQ[0].instr));
      checkOutput("head_pc", 32'(oPc), 32'(refQ[0].pc));
    end
    doPush = valid && expReady && !rst;
    doPop  = expValid && outRdy && !flush && !rst;
    if (rst || (flush && !halt)) begin
      refQ.delete();
      expQ.delete();
    end else begin
      if (doPop) void'(refQ.pop_front());
      if (doPush) begin
        e.instr = instr;
        e.pc    = pc;
        refQ.push_back(e);
        expQ.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop must match the oldest outstanding push.
  always @(negedge clk) begin
    entry_t e;
    if (!rstIn && oOutValid && outReady && !flushIn) begin
      if (expQ.size() == 0) begin
        checkOutput("pop_underflow", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("pop_instr", 32'(oInstr), 32'(e.instr));
        checkOutput("pop_pc", 32'(oPc), 32'(e.pc));
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    applyStimulus(0, '0, '0, 0, 0, 0, 1);
    applyStimulus(0, '0, '0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++)
      applyStimulus(1, 16'h1111 * 16'(i + 1), 10'h010 + 10'(i), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, '0, '0, 1, 0, 0, 0);

    applyStimulus(1, 16'hA001, 10'h100, 0, 0, 0, 0);
    applyStimulus(1, 16'hA002, 10'h101, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 16'(16'hB000 + i), 10'(10'h200 + i), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, '0, '0, 1, 0, 0, 0);

    for (int i = 0; i < 3; i++)
      applyStimulus(1, 16'(16'hC000 + i), 10'(10'h300 + i), 0, 0, 0, 0);
    applyStimulus(1, 16'hBEEF, 10'h3FF, 1, 1, 0, 0);
    applyStimulus(0, '0, '0, 1, 0, 0, 0);

    applyStimulus(1, 16'hD001, 10'h040, 0, 0, 0, 0);
    applyStimulus(1, 16'hD002, 10'h041, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 16'hEEEE, 10'h155, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, '0, '0, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom), 10'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 63) == 0));
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus(0, '0, '0, 1, 0, 0, 0);
    checkOutput("leftover_entries", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
